// File: rtl/gaussian_frame_ctrl.sv
// Frame sequencer wrapped around a 3x3 Gaussian filter: feeds one frame of
// upstream pixels, flushes the filter line buffers, then tags and counts outputs.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 frame request (IDLE only)
//   cfg_width, cfg_height frame dimensions, sampled on accepted start
//   s_data/s_valid/s_ready upstream pixel handshake (ready only in FEED)
//   f_data_in/f_data_valid pixel stream into the filter (incl. flush pixels)
//   f_img_width           line width to the filter, stable while busy
//   f_data_out/_valid     filtered pixel stream from the filter
//   m_data/m_valid        tagged output pixel, with m_sof and m_eol markers
//   busy, frame_done      activity level and one-cycle completion pulse
//   timeout, cfg_err, overflow  sticky status, cleared on accepted start
module gaussian_frame_ctrl #(
    parameter int DATA_W      = 8,
    parameter int DIM_W       = 12,
    parameter int FLUSH_EXTRA = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] f_data_in,
    output logic              f_data_valid,
    output logic [DIM_W-1:0]  f_img_width,
    input  logic [DATA_W-1:0] f_data_out,
    input  logic              f_data_out_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_sof,
    output logic              m_eol,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout,
    output logic              cfg_err,
    output logic              overflow
);

    localparam int CNT_W = 2 * DIM_W;
    localparam int FL_W  = DIM_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [DIM_W-1:0]   width_q;
    logic [DIM_W-1:0]   height_q;
    logic [CNT_W-1:0]   total_q;
    logic [CNT_W-1:0]   in_cnt_q;
    logic [CNT_W-1:0]   out_cnt_q;
    logic [DIM_W-1:0]   out_col_q;
    logic [FL_W-1:0]    flush_cnt_q;
    logic [TO_W-1:0]    idle_q;

    logic               dims_ok;
    logic               s_fire;
    logic               out_active;
    logic               out_take;
    logic               out_drop;
    logic               last_in;
    logic               flush_last;
    logic               col_last;
    logic               idle_hit;
    logic [FL_W-1:0]    flush_len_m1;
    logic [CNT_W-1:0]   in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_d;
    logic [FL_W-1:0]    flush_cnt_d;
    logic [TO_W-1:0]    idle_d;

    always_comb begin
        dims_ok      = (cfg_width >= DIM_W'(3)) && (cfg_height >= DIM_W'(3));
        s_fire       = (state_q == S_FEED) && s_valid && s_ready;
        out_active   = (state_q == S_FEED) || (state_q == S_FLUSH)
                    || (state_q == S_DRAIN);
        out_take     = out_active && f_data_out_valid && (out_cnt_q < total_q);
        // Surplus filter outputs are only an error while a frame is open;
        // LOAD still holds the previous frame's counters, so it is excluded.
        out_drop     = (out_active || (state_q == S_DONE)) && f_data_out_valid
                    && (out_cnt_q >= total_q);
        last_in      = (in_cnt_q == total_q - CNT_W'(1));
        flush_len_m1 = {1'b0, width_q} + FL_W'(FLUSH_EXTRA) - FL_W'(1);
        flush_last   = (flush_cnt_q == flush_len_m1);
        col_last     = (out_col_q == width_q - DIM_W'(1));
        idle_hit     = (idle_q == TO_W'(TIMEOUT - 1));
        in_cnt_d     = in_cnt_q + CNT_W'(1);
        out_cnt_d    = out_cnt_q + CNT_W'(1);
        flush_cnt_d  = flush_cnt_q;
        if (flush_cnt_q != {FL_W{1'b1}}) begin
            flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
        idle_d = idle_q;
        if (f_data_out_valid) begin
            idle_d = '0;
        end else if (idle_q < TO_W'(TIMEOUT)) begin
            idle_d = idle_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            total_q      <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            out_col_q    <= '0;
            flush_cnt_q  <= '0;
            idle_q       <= '0;
            s_ready      <= 1'b0;
            f_data_in    <= '0;
            f_data_valid <= 1'b0;
            f_img_width  <= '0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            m_sof        <= 1'b0;
            m_eol        <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            timeout      <= 1'b0;
            cfg_err      <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            frame_done   <= 1'b0;
            m_valid      <= 1'b0;
            m_sof        <= 1'b0;
            m_eol        <= 1'b0;
            f_data_valid <= 1'b0;

            if (out_take) begin
                m_data    <= f_data_out;
                m_valid   <= 1'b1;
                m_sof     <= (out_cnt_q == '0);
                m_eol     <= col_last;
                out_cnt_q <= out_cnt_d;
                out_col_q <= col_last ? '0 : out_col_q + DIM_W'(1);
            end
            if (out_drop) begin
                overflow <= 1'b1;
            end
            if (out_active) begin
                idle_q <= idle_d;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (dims_ok) begin
                            width_q  <= cfg_width;
                            height_q <= cfg_height;
                            cfg_err  <= 1'b0;
                            timeout  <= 1'b0;
                            overflow <= 1'b0;
                            busy     <= 1'b1;
                            state_q  <= S_LOAD;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    f_img_width <= width_q;
                    total_q     <= CNT_W'(width_q) * CNT_W'(height_q);
                    in_cnt_q    <= '0;
                    out_cnt_q   <= '0;
                    out_col_q   <= '0;
                    flush_cnt_q <= '0;
                    idle_q      <= '0;
                    f_data_in   <= '0;
                    s_ready     <= 1'b1;
                    state_q     <= S_FEED;
                end
                S_FEED: begin
                    if (s_fire) begin
                        f_data_in    <= s_data;
                        f_data_valid <= 1'b1;
                        in_cnt_q     <= in_cnt_d;
                        if (last_in) begin
                            s_ready <= 1'b0;
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    f_data_in    <= '0;
                    f_data_valid <= 1'b1;
                    flush_cnt_q  <= flush_cnt_d;
                    if (flush_last) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_cnt_q == total_q) begin
                        frame_done <= 1'b1;
                        state_q    <= S_DONE;
                    end else if (!f_data_out_valid && idle_hit) begin
                        frame_done <= 1'b1;
                        timeout    <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gaussian_frame_ctrl.sv
// Bench for gaussian_frame_ctrl: random frames against a queue-based
// reference with a latency-configurable filter model.
module tb_gaussian_frame_ctrl;

    localparam int DATA_W  = 8;
    localparam int DIM_W   = 12;
    localparam int TIMEOUT = 4096;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [DIM_W-1:0]  cfg_width;
    logic [DIM_W-1:0]  cfg_height;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] f_data_in;
    logic              f_data_valid;
    logic [DIM_W-1:0]  f_img_width;
    logic [DATA_W-1:0] f_data_out;
    logic              f_data_out_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_sof;
    logic              m_eol;
    logic              busy;
    logic              frame_done;
    logic              timeout;
    logic              cfg_err;
    logic              overflow;

    int n_assert = 0;
    int n_fail   = 0;

    gaussian_frame_ctrl #(
        .DATA_W(DATA_W), .DIM_W(DIM_W), .FLUSH_EXTRA(2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .f_data_in(f_data_in), .f_data_valid(f_data_valid),
        .f_img_width(f_img_width),
        .f_data_out(f_data_out), .f_data_out_valid(f_data_out_valid),
        .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_eol(m_eol),
        .busy(busy), .frame_done(frame_done), .timeout(timeout),
        .cfg_err(cfg_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {19'(0), s_ready, f_data_valid, m_valid, m_sof, m_eol, busy,
                frame_done, timeout, cfg_err, overflow,
                |f_data_in, |f_img_width, |m_data};
    endfunction

    // mode: 0 s_valid always high, 1 toggling, 2 random.
    // withhold: filter drops its last N outputs; extra: emits N surplus.
    // abort_at: pulse reset once that many pixels have been accepted.
    task automatic run_frame(input int w, input int h, input int mode,
                             input int withhold, input int extra,
                             input int abort_at);
        int total, lat, limit, k, budget;
        int sent[$];
        int accepted = 0, nin = 0, flushn = 0;
        int flush_first = -1, flush_last = -1;
        int mcnt = 0, eolcnt = 0, done_cnt = 0;
        int last_m = -1, done_cyc = -1, cyc = 0;
        int bad_feed = 0, bad_flush = 0, bad_ready = 0;
        int bad_m = 0, bad_sof = 0, bad_eol = 0;
        logic tog = 1'b0;
        total  = w * h;
        lat    = (extra > 0) ? w - 1 : w + 2;
        limit  = total - withhold + extra;
        budget = 4 * total + TIMEOUT + 200;

        @(negedge clk);
        start      = 1'b1;
        cfg_width  = DIM_W'(w);
        cfg_height = DIM_W'(h);
        @(negedge clk);
        start = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_ready", 32'(s_ready), 32'd0);
        chk("load_sticky", {29'(0), timeout, cfg_err, overflow}, 32'd0);
        @(negedge clk);
        chk("feed_ready", 32'(s_ready), 32'd1);
        chk("img_width", 32'(f_img_width), 32'(w));

        while (cyc < budget) begin
            if (f_data_valid) begin
                if (nin < total) begin
                    if (nin >= sent.size() || f_data_in !== 8'(sent[nin]))
                        bad_feed++;
                end else begin
                    if (f_data_in !== '0) bad_flush++;
                    if (s_ready) bad_ready++;
                    if (flush_first < 0) flush_first = cyc;
                    flush_last = cyc;
                    flushn++;
                end
            end
            f_data_out_valid = 1'b0;
            f_data_out       = '0;
            if (f_data_valid) begin
                k = nin - lat;
                if (k >= 0 && k < limit) begin
                    f_data_out_valid = 1'b1;
                    f_data_out       = 8'(k ^ 32'hA5);
                end
                nin++;
            end
            if (m_valid) begin
                if (m_data !== 8'(mcnt ^ 32'hA5)) bad_m++;
                if (m_sof !== (mcnt == 0)) bad_sof++;
                if (m_eol !== ((mcnt % w) == w - 1)) bad_eol++;
                if (m_eol) eolcnt++;
                last_m = cyc;
                mcnt++;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (s_ready && accepted >= total) bad_ready++;

            // a start while busy must be ignored
            start     = (mode == 2 && cyc == 5);
            cfg_width = (cyc == 5) ? DIM_W'(3) : DIM_W'(w);
            tog = ~tog;
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = tog;
                default: s_valid = ($urandom_range(0, 3) != 0);
            endcase
            s_data = 8'($urandom);
            if (s_valid && s_ready) begin
                sent.push_back(int'(s_data));
                accepted++;
            end

            if (abort_at > 0 && accepted == abort_at) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("abort_outs", all_outs(), 32'd0);
                s_valid = 1'b0;
                start   = 1'b0;
                f_data_out_valid = 1'b0;
                @(negedge clk);
                chk("abort_hold", all_outs(), 32'd0);
                rst_n = 1'b1;
                @(negedge clk);
                chk("abort_idle", {30'(0), busy, frame_done}, 32'd0);
                return;
            end

            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(negedge clk);
            cyc++;
        end
        start            = 1'b0;
        s_valid          = 1'b0;
        f_data_out_valid = 1'b0;

        chk("accepted", 32'(accepted), 32'(total));
        chk("fed_total", 32'(nin), 32'(total + w + 2));
        chk("flush_len", 32'(flushn), 32'(w + 2));
        chk("flush_contig", 32'(flush_last - flush_first), 32'(w + 1));
        chk("feed_order", 32'(bad_feed), 32'd0);
        chk("flush_zero", 32'(bad_flush), 32'd0);
        chk("ready_phase", 32'(bad_ready), 32'd0);
        chk("m_count", 32'(mcnt), 32'(total - withhold));
        chk("m_data", 32'(bad_m), 32'd0);
        chk("m_sof", 32'(bad_sof), 32'd0);
        chk("m_eol", 32'(bad_eol), 32'd0);
        chk("eol_count", 32'(eolcnt), 32'((total - withhold) / w));
        chk("done_count", 32'(done_cnt), 32'd1);
        if (withhold > 0)
            chk("timeout_gap", 32'(done_cyc - last_m), 32'(TIMEOUT));
        else if (extra == 0)
            chk("done_gap", 32'(done_cyc - last_m), 32'd1);
        chk("timeout_flag", 32'(timeout), 32'(withhold > 0));
        chk("overflow_flag", 32'(overflow), 32'(extra > 0));
        chk("idle_busy", 32'(busy), 32'd0);
        chk("width_hold", 32'(f_img_width), 32'(w));
    endtask

    initial begin
        rst_n            = 1'b0;
        start            = 1'b0;
        cfg_width        = '0;
        cfg_height       = '0;
        s_data           = '0;
        s_valid          = 1'b0;
        f_data_out       = '0;
        f_data_out_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset", all_outs(), 32'd0);

        run_frame(16, 12, 0, 0, 0, 0);
        run_frame(4, 3, 1, 0, 0, 0);
        run_frame(8, 6, 2, 5, 0, 0);
        run_frame(10, 5, 2, 0, 3, 0);

        // surplus outputs in IDLE: dropped silently
        @(negedge clk);
        f_data_out_valid = 1'b1;
        f_data_out       = 8'h3C;
        @(negedge clk);
        chk("idle_drop_m", 32'(m_valid), 32'd0);
        chk("idle_drop_ovf", 32'(overflow), 32'd1);
        f_data_out_valid = 1'b0;

        @(negedge clk);
        start      = 1'b1;
        cfg_width  = DIM_W'(2);
        cfg_height = DIM_W'(5);
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_w", 32'(cfg_err), 32'd1);
        chk("cfg_err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("cfg_err_idle", 32'(busy), 32'd0);
        start      = 1'b1;
        cfg_width  = DIM_W'(7);
        cfg_height = DIM_W'(2);
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_h", {30'(0), cfg_err, busy}, 32'd2);

        run_frame(5, 5, 0, 0, 0, 0);
        run_frame(20, 10, 2, 0, 0, 50);
        run_frame(6, 4, 2, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gaussian_frame_ctrl.md
# gaussian_frame_ctrl

Frame sequencer that sits in front of and behind the 3x3 Gaussian filter. It accepts a frame request and dimensions, then streams upstream pixels into the filter under a valid/ready handshake. After the last real pixel it feeds flush pixels so the filter's line buffers empty. It counts the filter's outputs, tags them with start-of-frame and end-of-line markers, and signals frame completion or timeout.

## Interface
- DATA_W, 8, pixel width
- DIM_W, 12, width/height field width
- FLUSH_EXTRA, 2, flush pixels fed beyond one full row (flush length = width + FLUSH_EXTRA)
- TIMEOUT, 4096, idle cycles in DRAIN before forced completion (counter width = $clog2(TIMEOUT)+1)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle frame request, honoured only in IDLE
- cfg_width  in  DIM_W  frame width in pixels, sampled on accepted start
- cfg_height  in  DIM_W  frame height in rows, sampled on accepted start
- s_data  in  DATA_W  upstream pixel
- s_valid  in  1  upstream pixel valid
- s_ready  out  1  controller accepts pixel
- f_data_in  out  DATA_W  pixel to filter
- f_data_valid  out  1  pixel-to-filter valid
- f_img_width  out  DIM_W  width to filter, stable while busy
- f_data_out  in  DATA_W  filtered pixel
- f_data_out_valid  in  1  filtered pixel valid
- m_data  out  DATA_W  tagged output pixel
- m_valid  out  1  output valid
- m_sof  out  1  first output pixel of frame
- m_eol  out  1  last output pixel of a row
- busy  out  1  high in all states except IDLE
- frame_done  out  1  one-cycle completion pulse
- timeout  out  1  sticky: frame ended by TIMEOUT; cleared on next accepted start
- cfg_err  out  1  sticky: start rejected for bad dimensions; cleared on next accepted start
- overflow  out  1  sticky: filter produced more than width*height outputs; cleared on next accepted start

## Operation
- States: IDLE, LOAD, FEED, FLUSH, DRAIN, DONE.
- IDLE → LOAD on start with 3 ≤ cfg_width and 3 ≤ cfg_height.
  - If start arrives with either dimension < 3: set cfg_err, stay IDLE.
- LOAD, 1 cycle:
  - latch width and height; drive f_img_width.
  - total = width*height (2*DIM_W bits).
  - clear in/out counters and sticky flags; go to FEED.
- FEED:
  - s_ready = 1.
  - Each s_valid&&s_ready transfers s_data to f_data_in and pulses f_data_valid.
  - After transfer number total, go to FLUSH.
- FLUSH:
  - Drive f_data_valid=1 with f_data_in=0 for exactly width+FLUSH_EXTRA consecutive cycles; s_ready=0.
  - Then go to DRAIN.
- DRAIN:
  - Go to DONE when out_count reaches total.
  - Also go to DONE after TIMEOUT consecutive cycles without f_data_out_valid; set timeout in that case.
- DONE, 1 cycle: frame_done=1, then IDLE.
- Output path (FEED/FLUSH/DRAIN, and the DONE-entry cycle):
  - Each f_data_out_valid with out_count < total is registered to m_data with m_valid=1.
  - out_col and out_row advance; out_col wraps at width-1.
  - m_sof=1 when out_count==0.
  - m_eol=1 when out_col==width-1.
- Outputs arriving after out_count==total, in any state including IDLE: dropped.
  - Dropped while busy → set overflow. Dropped in IDLE → ignore silently.
- start while busy: ignored.
- Counters: in_count and out_count are 2*DIM_W bits; flush and timeout counters saturate, never wrap.

## Timing
- Reset values: s_ready=0, f_data_in=0, f_data_valid=0, f_img_width=0, m_data=0, m_valid=0, m_sof=0, m_eol=0, busy=0, frame_done=0, timeout=0, cfg_err=0, overflow=0; state IDLE.
- Reset asserted mid-frame: all of the above immediately, asynchronously. No partial-frame completion pulse.
- start sampled at cycle t → busy=1 at t+1 (LOAD) → s_ready=1 at t+2.
- Pixel path latency: s_data accepted at edge t → f_data_in/f_data_valid valid after t (registered, 1 cycle).
- Output path latency: f_data_out_valid at edge t → m_valid after t (1 cycle). m_sof and m_eol are aligned with m_valid.
- Last output and filter output in the same cycle: last output is still counted and forwarded; frame_done follows one cycle after the final m_valid.
- FLUSH pixels are never stalled; upstream backpressure applies in FEED only.
- f_img_width changes only in LOAD.

## Test plan
- 640x480 random stream, s_valid always 1:
  - 307200 transfers, then exactly 642 flush pixels.
  - m_sof on output 0; m_eol on every 640th output (480 total); frame_done once.
  - timeout=overflow=0.
- 4x3 frame with s_valid toggling 1/0 every cycle: s_ready high only in FEED; exactly 12 pixels forwarded in order; flush length 6.
- Filter model withholds the last 5 outputs: exactly TIMEOUT=4096 idle cycles after the previous output, frame_done with timeout=1.
- Filter model emits 3 extra outputs: only 307200 m_valid, overflow=1; the next start clears it.
- start with cfg_width=2: cfg_err=1, busy stays 0. start with 5x5: cfg_err clears, frame completes with 25 outputs.
- rst_n low mid-FEED at pixel 1000: all outputs reach reset values the same cycle; a fresh start runs a complete frame normally.
